// File: rtl/fwd_hazard_unit.sv
// Scoreboard-based RAW/WAW hazard detection with zero-latency operand forwarding.
// Optional stall-cycle counter is built only when FWD_STALL_CNT_EN is defined.
module fwd_hazard_unit #(
    parameter  int DATA_W  = 32,
    parameter  int REG_AW  = 5,
    parameter  int NSRC    = 2,
    parameter  int NFWD    = 2,
    parameter  int MAX_LAT = 4,
    localparam int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic [REG_AW-1:0]        issue_rd,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic                     flush,
    input  logic [NSRC-1:0]          src_used,
    input  logic [NSRC*REG_AW-1:0]   src_addr,
    input  logic [NSRC*DATA_W-1:0]   src_rdata,
    input  logic [NFWD-1:0]          fwd_valid,
    input  logic [NFWD*REG_AW-1:0]   fwd_rd,
    input  logic [NFWD*DATA_W-1:0]   fwd_data,
    output logic [NSRC*DATA_W-1:0]   src_fdata,
    output logic                     stall,
    output logic [31:0]              stall_cycles
);

    localparam int               NREG      = 1 << REG_AW;
    localparam logic [LAT_W-1:0] LAT_MAX_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] r_pend [NREG];
    logic [LAT_W-1:0] w_latClamped;
    logic             w_rawHazard;
    logic             w_wawHazard;
    logic             w_stall;
    logic             w_accept;
    logic             w_load;

    always_comb begin
        w_latClamped = (issue_lat > LAT_MAX_V) ? LAT_MAX_V : issue_lat;
    end

    // A used operand stalls while its producer's result is still off the buses.
    always_comb begin
        w_rawHazard = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_used[i] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                (r_pend[src_addr[i*REG_AW +: REG_AW]] != '0)) begin
                w_rawHazard = 1'b1;
            end
        end
    end

    always_comb begin
        w_wawHazard = issue_wen && (issue_rd != '0) && (r_pend[issue_rd] > w_latClamped);
        w_stall     = !rst && issue_valid && (w_rawHazard || w_wawHazard);
        w_accept    = issue_valid && !w_stall && !flush;
        w_load      = w_accept && issue_wen && (issue_rd != '0);
    end

    // A fresh load of a register's latency takes priority over its countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                r_pend[r] <= '0;
            end
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0) begin
                    r_pend[r] <= '0;
                end else if (w_load && (issue_rd == REG_AW'(r))) begin
                    r_pend[r] <= w_latClamped;
                end else if (r_pend[r] != '0) begin
                    r_pend[r] <= r_pend[r] - LAT_W'(1);
                end
            end
        end
    end

    // Walk buses oldest to youngest so the youngest match is written last and wins.
    always_comb begin
        src_fdata = src_rdata;
        for (int i = 0; i < NSRC; i++) begin
            for (int j = NFWD - 1; j >= 0; j--) begin
                if (fwd_valid[j] && (src_addr[i*REG_AW +: REG_AW] != '0) &&
                    (fwd_rd[j*REG_AW +: REG_AW] == src_addr[i*REG_AW +: REG_AW])) begin
                    src_fdata[i*DATA_W +: DATA_W] = fwd_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign stall = w_stall;

`ifdef FWD_STALL_CNT_EN
    logic [31:0] r_stallCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cycles = r_stallCnt;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
